// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio PCM FIFO refill controller.
package audio_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 17;
    localparam int unsigned DEFAULT_BURST_LEN  = 16;
    localparam int unsigned LEN_WIDTH          = 16;
    localparam int unsigned BYTE_WIDTH         = 8;
    localparam int unsigned BURST_WIDTH        = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_REQ  = 2'd2,
        ST_PUSH = 2'd3
    } state_e;

endpackage

// File: rtl/audio_fifo_dma.sv
// Audio FIFO refill controller: fetches PCM bytes in bursts on almost-empty
// and shares the FIFO write port with host writes (host has priority).
module audio_fifo_dma
    import audio_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned BURST_LEN  = DEFAULT_BURST_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_enable,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
    input  logic [LEN_WIDTH-1:0]  cfg_length,
    input  logic                  cfg_loop,
    output logic                  busy,
    output logic                  done_irq,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [BYTE_WIDTH-1:0] mem_rddata,
    input  logic [BYTE_WIDTH-1:0] cpu_fifo_wrdata,
    input  logic                  cpu_fifo_write,
    input  logic                  fifo_full,
    input  logic                  fifo_almost_empty,
    output logic [BYTE_WIDTH-1:0] fifo_wrdata,
    output logic                  fifo_write
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [BURST_WIDTH-1:0]  burst_q, burst_d;
    logic [BYTE_WIDTH-1:0]   dma_byte_q, dma_byte_d;
    logic                    abort_q, abort_d;
    logic                    busy_d, done_irq_d, mem_req_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic                    dma_push_c;
    logic [ADDR_WIDTH-1:0]   addr_inc_c;

    // DMA byte goes out only when the host is not writing and the FIFO has room.
    assign dma_push_c  = (state_q == ST_PUSH) && cfg_enable && !fifo_full && !cpu_fifo_write;
    assign addr_inc_c  = addr_q + ADDR_WIDTH'(1);

    // Write-port mux: host strobe always wins; a blocked DMA byte is simply retried.
    assign fifo_write  = cpu_fifo_write | dma_push_c;
    assign fifo_wrdata = cpu_fifo_write ? cpu_fifo_wrdata : dma_byte_q;

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        dma_byte_d  = dma_byte_q;
        abort_d     = abort_q;
        busy_d      = busy;
        done_irq_d  = 1'b0;
        mem_req_d   = mem_req;
        mem_addr_d  = mem_addr;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start && cfg_enable && (cfg_length != '0)) begin
                    state_d     = ST_WAIT;
                    addr_d      = cfg_start_addr;
                    remaining_d = cfg_length;
                    busy_d      = 1'b1;
                    abort_d     = 1'b0;
                end
            end
            ST_WAIT: begin
                burst_d = BURST_WIDTH'(BURST_LEN);
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (fifo_almost_empty) begin
                    state_d    = ST_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = addr_q;
                end
            end
            ST_REQ: begin
                // An abort cannot withdraw the request; remember it until the ack.
                if (!cfg_enable) begin
                    abort_d = 1'b1;
                end
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    dma_byte_d = mem_rddata;
                    if (abort_q || !cfg_enable) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        abort_d = 1'b0;
                    end else begin
                        state_d = ST_PUSH;
                    end
                end
            end
            ST_PUSH: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (dma_push_c) begin
                    addr_d      = addr_inc_c;
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    burst_d     = burst_q - BURST_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        if (cfg_loop && (cfg_length != '0)) begin
                            state_d     = ST_WAIT;
                            addr_d      = cfg_start_addr;
                            remaining_d = cfg_length;
                        end else begin
                            state_d    = ST_IDLE;
                            busy_d     = 1'b0;
                            done_irq_d = 1'b1;
                        end
                    end else if (burst_q == BURST_WIDTH'(1)) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = addr_inc_c;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            dma_byte_q  <= '0;
            abort_q     <= 1'b0;
            busy        <= 1'b0;
            done_irq    <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            dma_byte_q  <= dma_byte_d;
            abort_q     <= abort_d;
            busy        <= busy_d;
            done_irq    <= done_irq_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
        end
    end

endmodule

// File: tb/tb_audio_fifo_dma.sv
// Directed bench for audio_fifo_dma: memory responder, FIFO write monitor,
// linear stimulus with immediate-assertion checks.
module tb_audio_fifo_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_enable;
    logic        cfg_start;
    logic [16:0] cfg_start_addr;
    logic [15:0] cfg_length;
    logic        cfg_loop;
    logic        busy;
    logic        done_irq;
    logic        mem_req;
    logic [16:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rddata;
    logic [7:0]  cpu_fifo_wrdata;
    logic        cpu_fifo_write;
    logic        fifo_full;
    logic        fifo_almost_empty;
    logic [7:0]  fifo_wrdata;
    logic        fifo_write;

    int n_checks = 0;
    int n_fail   = 0;
    int ack_delay = 0;
    int wait_cnt  = 0;
    int done_cnt  = 0;
    int done_busy_bad = 0;
    logic [7:0]  fifo_log[$];
    logic [16:0] addr_log[$];

    audio_fifo_dma dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_enable        (cfg_enable),
        .cfg_start         (cfg_start),
        .cfg_start_addr    (cfg_start_addr),
        .cfg_length        (cfg_length),
        .cfg_loop          (cfg_loop),
        .busy              (busy),
        .done_irq          (done_irq),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_ack           (mem_ack),
        .mem_rddata        (mem_rddata),
        .cpu_fifo_wrdata   (cpu_fifo_wrdata),
        .cpu_fifo_write    (cpu_fifo_write),
        .fifo_full         (fifo_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_wrdata       (fifo_wrdata),
        .fifo_write        (fifo_write)
    );

    always #5 clk = ~clk;

    // Memory model: ack after ack_delay waiting cycles, data = addr[7:0] ^ 0xA0.
    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack    = 1'b1;
                mem_rddata = mem_addr[7:0] ^ 8'hA0;
                addr_log.push_back(mem_addr);
                wait_cnt   = 0;
            end else begin
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // FIFO-side monitor.
    always @(negedge clk) begin
        if (fifo_write === 1'b1) fifo_log.push_back(fifo_wrdata);
        if (done_irq === 1'b1) begin
            done_cnt = done_cnt + 1;
            if (busy !== 1'b0) done_busy_bad = done_busy_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        fifo_log.delete();
        addr_log.delete();
        done_cnt      = 0;
        done_busy_bad = 0;
    endtask

    task automatic start_xfer(input logic [16:0] a, input logic [15:0] len, input logic lp);
        cfg_start_addr = a;
        cfg_length     = len;
        cfg_loop       = lp;
        cfg_start      = 1'b1;
        tick;
        cfg_start      = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (busy === 1'b1 && n < limit) begin
            tick;
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_acks(input string tag, input int target, input int limit);
        int n = 0;
        while (addr_log.size() < target && n < limit) begin
            tick;
            n++;
        end
        chk(tag, 32'(addr_log.size()), 32'(target));
    endtask

    initial begin
        rst = 1'b0;
        cfg_enable = 1'b0; cfg_start = 1'b0; cfg_start_addr = '0; cfg_length = '0;
        cfg_loop = 1'b0; mem_ack = 1'b0; mem_rddata = '0;
        cpu_fifo_wrdata = '0; cpu_fifo_write = 1'b0;
        fifo_full = 1'b0; fifo_almost_empty = 1'b0;

        // Reset state and host passthrough.
        tick; tick;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(done_irq), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_fwr", 32'(fifo_write), 32'd0);
        cpu_fifo_wrdata = 8'h5A; cpu_fifo_write = 1'b1;
        #1;
        chk("cpu_pass_wr", 32'(fifo_write), 32'd1);
        chk("cpu_pass_data", 32'(fifo_wrdata), 32'h5A);
        cpu_fifo_write = 1'b0;
        tick;
        rst = 1'b1;
        tick;

        // Basic 4-byte transfer, ack one cycle after the request.
        clear_logs;
        ack_delay = 1; cfg_enable = 1'b1; fifo_almost_empty = 1'b1;
        start_xfer(17'h00100, 16'd4, 1'b0);
        chk("lat_busy", 32'(busy), 32'd1);
        chk("lat_req_e1", 32'(mem_req), 32'd0);
        tick;
        chk("lat_req_e2", 32'(mem_req), 32'd1);
        chk("lat_addr", 32'(mem_addr), 32'h100);
        wait_idle("basic_idle", 100);
        tick; tick;
        chk("basic_nacks", 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_addr%0d", i), 32'(addr_log[i]), 32'h100 + 32'(i));
        chk("basic_nbytes", 32'(fifo_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("basic_byte%0d", i), 32'(fifo_log[i]), 32'hA0 + 32'(i));
        chk("basic_done", 32'(done_cnt), 32'd1);
        chk("basic_done_busy", 32'(done_busy_bad), 32'd0);

        // Burst boundary: almost-empty withdrawn after 32 bytes.
        clear_logs;
        ack_delay = 0;
        start_xfer(17'h00200, 16'd40, 1'b0);
        wait_acks("burst_32", 32, 400);
        fifo_almost_empty = 1'b0;
        repeat (20) tick;
        chk("burst_stall_acks", 32'(addr_log.size()), 32'd32);
        chk("burst_stall_bytes", 32'(fifo_log.size()), 32'd32);
        chk("burst_stall_busy", 32'(busy), 32'd1);
        chk("burst_stall_req", 32'(mem_req), 32'd0);
        fifo_almost_empty = 1'b1;
        wait_idle("burst_idle", 200);
        tick; tick;
        chk("burst_acks", 32'(addr_log.size()), 32'd40);
        chk("burst_resume_addr", 32'(addr_log[32]), 32'h220);
        chk("burst_bytes", 32'(fifo_log.size()), 32'd40);
        chk("burst_last", 32'(fifo_log[39]), 32'h87);
        chk("burst_done", 32'(done_cnt), 32'd1);

        // FIFO full stall, then host collision.
        fifo_full = 1'b1;
        clear_logs;
        start_xfer(17'h00300, 16'd1, 1'b0);
        wait_acks("full_ack", 1, 50);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk($sformatf("full_req%0d", i), 32'(mem_req), 32'd0);
            chk($sformatf("full_wr%0d", i), 32'(fifo_write), 32'd0);
        end
        fifo_full = 1'b0; cpu_fifo_wrdata = 8'h55; cpu_fifo_write = 1'b1;
        tick; tick;
        cpu_fifo_write = 1'b0;
        wait_idle("full_idle", 20);
        tick; tick;
        chk("coll_n", 32'(fifo_log.size()), 32'd3);
        chk("coll_b0", 32'(fifo_log[0]), 32'h55);
        chk("coll_b1", 32'(fifo_log[1]), 32'h55);
        chk("coll_b2", 32'(fifo_log[2]), 32'hA0);
        chk("coll_done", 32'(done_cnt), 32'd1);

        // Loop with address wrap, then abort.
        clear_logs;
        start_xfer(17'h1FFFE, 16'd3, 1'b1);
        wait_acks("loop_acks", 4, 100);
        chk("loop_busy", 32'(busy), 32'd1);
        cfg_enable = 1'b0;
        wait_idle("loop_idle", 50);
        cfg_loop = 1'b0;
        tick; tick;
        chk("loop_a0", 32'(addr_log[0]), 32'h1FFFE);
        chk("loop_a1", 32'(addr_log[1]), 32'h1FFFF);
        chk("loop_a2", 32'(addr_log[2]), 32'h00000);
        chk("loop_a3", 32'(addr_log[3]), 32'h1FFFE);
        chk("loop_done", 32'(done_cnt), 32'd0);

        // Abort with an outstanding request.
        clear_logs;
        cfg_enable = 1'b1; ack_delay = 4;
        start_xfer(17'h00400, 16'd4, 1'b0);
        begin
            int n = 0;
            while (mem_req !== 1'b1 && n < 20) begin tick; n++; end
        end
        chk("abort_req_up", 32'(mem_req), 32'd1);
        cfg_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("abort_hold%0d", i), 32'(mem_req), 32'd1);
        end
        wait_idle("abort_idle", 20);
        tick; tick;
        chk("abort_req_down", 32'(mem_req), 32'd0);
        chk("abort_acks", 32'(addr_log.size()), 32'd1);
        chk("abort_bytes", 32'(fifo_log.size()), 32'd0);
        chk("abort_done", 32'(done_cnt), 32'd0);

        // Async reset while parked in PUSH.
        clear_logs;
        cfg_enable = 1'b1; ack_delay = 0; fifo_full = 1'b1;
        start_xfer(17'h00500, 16'd2, 1'b0);
        wait_acks("arst_ack", 1, 50);
        chk("arst_busy_pre", 32'(busy), 32'd1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_done", 32'(done_irq), 32'd0);
        #3 rst = 1'b1;
        fifo_full = 1'b0;
        tick;
        clear_logs;
        start_xfer(17'h00600, 16'd0, 1'b0);
        repeat (8) tick;
        chk("len0_busy", 32'(busy), 32'd0);
        chk("len0_req", 32'(mem_req), 32'd0);
        chk("len0_acks", 32'(addr_log.size()), 32'd0);
        chk("len0_bytes", 32'(fifo_log.size()), 32'd0);
        chk("len0_done", 32'(done_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
